sync_fifo_thr: RTL and testbench

Parametrised synchronous FIFO, successor to the bridge's request/response FIFO. It adds:
- selectable registered-read or first-word-fall-through (FWFT) output;
- programmable almost-full/almost-empty thresholds and an occupancy count;
- read-while-full pass-through;
- sticky overflow/underflow error flags;
- a synchronous flush.

It buffers packed command words (data+addr+cmd+byte_en) between the APB4 bridge front end and the APB master state machine.

---
 rtl/sync_fifo_thr_if.sv | 32 +++
 rtl/sync_fifo_thr.sv | 84 ++++++++
 tb/tb_sync_fifo_thr.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_thr_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo_thr.
// The master side drives requests and data; the slave side is the FIFO itself.
interface sync_fifo_thr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] datain;
  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] dataout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, clr_err, datain, w_en, r_en,
    input  dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, datain, w_en, r_en,
    output dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_thr.sv
// Synchronous FIFO with registered or fall-through read, occupancy thresholds,
// read-while-full pass-through, sticky overflow/underflow flags and flush.
module sync_fifo_thr #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic               clk,
  input  logic               reset,
  sync_fifo_thr_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wrPtr;
  logic [AW:0]           r_rdPtr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [CW-1:0]         w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_rdAcc;
  logic                  w_wrAcc;

  // Extra wrap bit on the pointers makes the difference the true occupancy.
  assign w_count = r_wrPtr - r_rdPtr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == CW'(DEPTH));
  assign w_rdAcc = bus.r_en & ~w_empty;
  assign w_wrAcc = bus.w_en & (~w_full | w_rdAcc);

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrAcc) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_rdAcc) r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !bus.flush && w_wrAcc)
      r_mem[r_wrPtr[AW-1:0]] <= bus.datain;
  end

  // A new error event wins over a same-cycle clear request.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (bus.w_en & ~w_wrAcc) | (r_overflow & ~bus.clr_err);
      r_underflow <= (bus.r_en & w_empty) | (r_underflow & ~bus.clr_err);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dataout = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
    end else begin : g_regRead
      logic [DATA_WIDTH-1:0] r_dataout;
      always_ff @(posedge clk) begin
        if (reset)
          r_dataout <= '0;
        else if (!bus.flush && w_rdAcc)
          r_dataout <= r_mem[r_rdPtr[AW-1:0]];
      end
      assign bus.dataout = r_dataout;
    end
  endgenerate

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (w_count >= CW'(AF_LEVEL));
  assign bus.almost_empty = (w_count <= CW'(AE_LEVEL));
  assign bus.count        = w_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_thr.sv
// Drives a registered-read and a fall-through instance of sync_fifo_thr with the
// same stimulus and compares both against a queue-based reference model.
module tb_sync_fifo_thr;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  logic          mOvf = 1'b0;
  logic          mUnf = 1'b0;
  logic [DW-1:0] mLast = '0;

  sync_fifo_thr_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifA ();
  sync_fifo_thr_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifB ();

  sync_fifo_thr #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE))
    dutA (.clk(clk), .reset(reset), .bus(ifA));
  sync_fifo_thr #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE))
    dutB (.clk(clk), .reset(reset), .bus(ifB));

  always #5 clk = ~clk;

  // Expected {full, empty, almost_full, almost_empty, overflow, underflow, count}.
  function automatic logic [6+CW-1:0] expStatus();
    int n;
    n = mq.size();
    return {n == DEPTH, n == 0, n >= AF, n <= AE, mOvf, mUnf, CW'(n)};
  endfunction

  function automatic logic [DW-1:0] expFwft();
    return (mq.size() == 0) ? '0 : mq[0];
  endfunction

  // Applies one cycle of stimulus to both instances and advances the model.
  task automatic drive(input logic rst, input logic fl, input logic clr,
                       input logic w, input logic r, input logic [DW-1:0] d);
    bit rdAcc, wrAcc, ovfSet, unfSet;
    @(negedge clk);
    reset = rst;
    ifA.flush = fl; ifA.clr_err = clr; ifA.w_en = w; ifA.r_en = r; ifA.datain = d;
    ifB.flush = fl; ifB.clr_err = clr; ifB.w_en = w; ifB.r_en = r; ifB.datain = d;
    @(posedge clk);
    if (rst) begin
      mq.delete(); mOvf = 1'b0; mUnf = 1'b0; mLast = '0;
    end else if (fl) begin
      mq.delete(); mOvf = 1'b0; mUnf = 1'b0;
    end else begin
      rdAcc  = r && (mq.size() != 0);
      wrAcc  = w && ((mq.size() < DEPTH) || rdAcc);
      ovfSet = w && !wrAcc;
      unfSet = r && (mq.size() == 0);
      if (rdAcc) mLast = mq.pop_front();
      if (wrAcc) mq.push_back(d);
      mOvf = ovfSet | (mOvf & ~clr);
      mUnf = unfSet | (mUnf & ~clr);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, 0, '0);
    checks++;
    if ({ifA.full, ifA.empty, ifA.almost_full, ifA.almost_empty, ifA.overflow, ifA.underflow, ifA.count} !== {6'b010100, CW'(0)}) begin
      errors++; $display("[TB] FAIL reset_status_A: got %b expected %b", {ifA.full, ifA.empty, ifA.almost_full, ifA.almost_empty, ifA.overflow, ifA.underflow, ifA.count}, {6'b010100, CW'(0)});
    end
    checks++;
    if ({ifB.full, ifB.empty, ifB.almost_full, ifB.almost_empty, ifB.overflow, ifB.underflow, ifB.count} !== {6'b010100, CW'(0)}) begin
      errors++; $display("[TB] FAIL reset_status_B: got %b expected %b", {ifB.full, ifB.empty, ifB.almost_full, ifB.almost_empty, ifB.overflow, ifB.underflow, ifB.count}, {6'b010100, CW'(0)});
    end
    checks++;
    if (ifA.dataout !== '0 || ifB.dataout !== '0) begin
      errors++; $display("[TB] FAIL reset_dataout: got A=%h B=%h expected 0", ifA.dataout, ifB.dataout);
    end
    drive(0, 0, 0, 0, 0, '0);
  endtask

  task automatic test_fill_overflow();
    logic [DW-1:0] words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, words[i]);
    checks++;
    if (ifA.count !== CW'(4) || ifA.full !== 1'b1 || ifA.almost_full !== 1'b1) begin
      errors++; $display("[TB] FAIL fill_full: got count=%0d full=%b af=%b expected 4 1 1", ifA.count, ifA.full, ifA.almost_full);
    end
    checks++;
    if (ifB.dataout !== 32'h11) begin
      errors++; $display("[TB] FAIL fill_fwft_head: got %h expected 11", ifB.dataout);
    end
    drive(0, 0, 0, 1, 0, 32'h55);
    checks++;
    if (ifA.overflow !== 1'b1 || ifB.overflow !== 1'b1 || ifA.count !== CW'(4)) begin
      errors++; $display("[TB] FAIL overflow_set: got A=%b B=%b count=%0d expected 1 1 4", ifA.overflow, ifB.overflow, ifA.count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, '0);
      checks++;
      if (ifA.dataout !== words[i]) begin
        errors++; $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, ifA.dataout, words[i]);
      end
    end
    checks++;
    if (ifA.empty !== 1'b1 || ifB.dataout !== '0) begin
      errors++; $display("[TB] FAIL drain_empty: got empty=%b fwft=%h expected 1 0", ifA.empty, ifB.dataout);
    end
    drive(0, 0, 0, 0, 1, '0);
    checks++;
    if (ifA.underflow !== 1'b1 || ifB.underflow !== 1'b1 || ifA.dataout !== 32'h44) begin
      errors++; $display("[TB] FAIL underflow_set: got A=%b B=%b dout=%h expected 1 1 44", ifA.underflow, ifB.underflow, ifA.dataout);
    end
    drive(0, 0, 1, 0, 0, '0);
    checks++;
    if ({ifA.overflow, ifA.underflow, ifB.overflow, ifB.underflow} !== 4'b0000) begin
      errors++; $display("[TB] FAIL clr_err: got %b expected 0000", {ifA.overflow, ifA.underflow, ifB.overflow, ifB.underflow});
    end
  endtask

  task automatic test_pass_through();
    logic [DW-1:0] words [4] = '{32'h22, 32'h33, 32'h44, 32'h55};
    drive(0, 0, 0, 1, 0, 32'h11);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, words[i]);
    drive(0, 0, 0, 1, 1, 32'h55);
    checks++;
    if (ifA.dataout !== 32'h11 || ifA.count !== CW'(4) || ifA.overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL pass_through: got dout=%h count=%0d ovf=%b expected 11 4 0", ifA.dataout, ifA.count, ifA.overflow);
    end
    checks++;
    if (ifB.dataout !== 32'h22 || ifB.full !== 1'b1) begin
      errors++; $display("[TB] FAIL pass_through_fwft: got dout=%h full=%b expected 22 1", ifB.dataout, ifB.full);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, '0);
      checks++;
      if (ifA.dataout !== words[i]) begin
        errors++; $display("[TB] FAIL pass_drain[%0d]: got %h expected %h", i, ifA.dataout, words[i]);
      end
    end
  endtask

  task automatic test_empty_simultaneous();
    drive(0, 0, 0, 1, 1, 32'hA5);
    checks++;
    if (ifA.count !== CW'(1) || ifA.underflow !== 1'b1 || ifA.dataout !== 32'h55) begin
      errors++; $display("[TB] FAIL empty_simul: got count=%0d unf=%b dout=%h expected 1 1 55", ifA.count, ifA.underflow, ifA.dataout);
    end
    checks++;
    if (ifB.dataout !== 32'hA5) begin
      errors++; $display("[TB] FAIL empty_simul_fwft: got %h expected a5", ifB.dataout);
    end
    drive(0, 0, 1, 0, 1, '0);
    checks++;
    if (ifA.dataout !== 32'hA5 || ifA.empty !== 1'b1 || ifA.underflow !== 1'b0) begin
      errors++; $display("[TB] FAIL empty_simul_read: got dout=%h empty=%b unf=%b expected a5 1 0", ifA.dataout, ifA.empty, ifA.underflow);
    end
  endtask

  task automatic test_fwft();
    drive(0, 0, 0, 1, 0, 32'h77);
    checks++;
    if (ifB.dataout !== 32'h77 || ifA.dataout !== 32'hA5) begin
      errors++; $display("[TB] FAIL fwft_latency: got B=%h A=%h expected 77 a5", ifB.dataout, ifA.dataout);
    end
    drive(0, 0, 0, 0, 1, '0);
    checks++;
    if (ifB.empty !== 1'b1 || ifB.dataout !== '0) begin
      errors++; $display("[TB] FAIL fwft_pop: got empty=%b dout=%h expected 1 0", ifB.empty, ifB.dataout);
    end
  endtask

  task automatic test_wrap_thresholds();
    logic [DW-1:0] sent [3];
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        sent[j] = $urandom;
        drive(0, 0, 0, 1, 0, sent[j]);
        checks++;
        if ({ifA.count, ifA.almost_empty, ifA.almost_full} !== {CW'(j + 1), (j + 1) <= AE, (j + 1) >= AF}) begin
          errors++; $display("[TB] FAIL thr_fill[%0d.%0d]: got count=%0d ae=%b af=%b expected count=%0d", k, j, ifA.count, ifA.almost_empty, ifA.almost_full, j + 1);
        end
      end
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (ifB.dataout !== sent[j]) begin
          errors++; $display("[TB] FAIL thr_fwft[%0d.%0d]: got %h expected %h", k, j, ifB.dataout, sent[j]);
        end
        drive(0, 0, 0, 0, 1, '0);
        checks++;
        if (ifA.dataout !== sent[j] || {ifA.almost_empty, ifA.almost_full} !== {(2 - j) <= AE, (2 - j) >= AF}) begin
          errors++; $display("[TB] FAIL thr_drain[%0d.%0d]: got dout=%h ae=%b af=%b expected %h", k, j, ifA.dataout, ifA.almost_empty, ifA.almost_full, sent[j]);
        end
      end
    end
  endtask

  task automatic test_flush_reset();
    logic [DW-1:0] held;
    held = ifA.dataout;
    drive(0, 0, 0, 0, 1, '0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, $urandom);
    drive(0, 1, 0, 1, 1, 32'hDEAD);
    checks++;
    if ({ifA.count, ifA.empty, ifA.overflow, ifA.underflow} !== {CW'(0), 3'b100} || ifA.dataout !== held) begin
      errors++; $display("[TB] FAIL flush: got count=%0d empty=%b ovf=%b unf=%b dout=%h expected 0 1 0 0 %h", ifA.count, ifA.empty, ifA.overflow, ifA.underflow, ifA.dataout, held);
    end
    checks++;
    if (ifB.empty !== 1'b1 || ifB.dataout !== '0) begin
      errors++; $display("[TB] FAIL flush_fwft: got empty=%b dout=%h expected 1 0", ifB.empty, ifB.dataout);
    end
    drive(0, 0, 0, 1, 0, 32'h1);
    drive(0, 0, 0, 1, 1, 32'h2);
    drive(1, 1, 0, 1, 1, 32'h3);
    checks++;
    if ({ifA.full, ifA.empty, ifA.almost_full, ifA.almost_empty, ifA.overflow, ifA.underflow, ifA.count} !== {6'b010100, CW'(0)} || ifA.dataout !== '0) begin
      errors++; $display("[TB] FAIL reset_with_flush: got status=%b dout=%h expected %b 0", {ifA.full, ifA.empty, ifA.almost_full, ifA.almost_empty, ifA.overflow, ifA.underflow, ifA.count}, ifA.dataout, {6'b010100, CW'(0)});
    end
    drive(0, 0, 0, 0, 0, '0);
  endtask

  task automatic test_random();
    logic [6+CW-1:0] exp;
    for (int i = 0; i < 400; i++) begin
      drive(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      exp = expStatus();
      checks++;
      if ({ifA.full, ifA.empty, ifA.almost_full, ifA.almost_empty, ifA.overflow, ifA.underflow, ifA.count} !== exp) begin
        errors++; $display("[TB] FAIL rand_status_A[%0d]: got %b expected %b", i, {ifA.full, ifA.empty, ifA.almost_full, ifA.almost_empty, ifA.overflow, ifA.underflow, ifA.count}, exp);
      end
      checks++;
      if ({ifB.full, ifB.empty, ifB.almost_full, ifB.almost_empty, ifB.overflow, ifB.underflow, ifB.count} !== exp) begin
        errors++; $display("[TB] FAIL rand_status_B[%0d]: got %b expected %b", i, {ifB.full, ifB.empty, ifB.almost_full, ifB.almost_empty, ifB.overflow, ifB.underflow, ifB.count}, exp);
      end
      checks++;
      if (ifA.dataout !== mLast || ifB.dataout !== expFwft()) begin
        errors++; $display("[TB] FAIL rand_data[%0d]: got A=%h B=%h expected A=%h B=%h", i, ifA.dataout, ifB.dataout, mLast, expFwft());
      end
    end
  endtask

  initial begin
    ifA.flush = 0; ifA.clr_err = 0; ifA.w_en = 0; ifA.r_en = 0; ifA.datain = '0;
    ifB.flush = 0; ifB.clr_err = 0; ifB.w_en = 0; ifB.r_en = 0; ifB.datain = '0;
    test_reset();
    test_fill_overflow();
    test_pass_through();
    test_empty_simultaneous();
    test_fwft();
    test_wrap_thresholds();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
